cache_arbiter: RTL

- Two-requester Wishbone arbiter in front of the shared cache/memory port (e.g. instruction fetch on port 0, data load/store on port 1).
- Registers a grant, forwards the granted requester's cycle to the single downstream secondary, and routes the ack back.
- Round-robin fairness, one transaction per grant.
- Sits between the core's fetch/LSU Wishbone buses and the cache's control-side wishbone_if.

---
 rtl/memory_pkg.sv | 16 +
 rtl/wishbone_if.sv | 31 +++
 rtl/rr_arbiter2.sv | 22 ++
 rtl/cache_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared memory-subsystem types: arbiter FSM states and the one-bit grant index.
package memory_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

    typedef logic [0:0] grant_t;

    function automatic arb_state_e grant_state(input grant_t g);
        return (g == grant_t'(1)) ? GRANT1 : GRANT0;
    endfunction

endpackage

// File: rtl/wishbone_if.sv
// Classic Wishbone bus bundle; "primary" drives the cycle, "secondary" answers it.
interface wishbone_if #(
    parameter int DATA_SIZE = 32,
    parameter int BYTE_SIZE = 8,
    parameter int ADDR_SIZE = 32
);
    localparam int SEL_SIZE = DATA_SIZE / BYTE_SIZE;

    // Handshake: a cycle is requested while cyc & stb are high; the primary keeps
    // cyc, stb, we, sel, addr and dat_o_p stable until it samples ack high, and ack
    // is a one-cycle completion strobe qualifying dat_i_p on reads.
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [SEL_SIZE-1:0]  sel;
    logic [ADDR_SIZE-1:0] addr;
    logic [DATA_SIZE-1:0] dat_o_p;
    logic [DATA_SIZE-1:0] dat_i_p;
    logic                 ack;

    modport primary (
        output cyc, stb, we, sel, addr, dat_o_p,
        input  ack, dat_i_p
    );

    modport secondary (
        input  cyc, stb, we, sel, addr, dat_o_p,
        output ack, dat_i_p
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie the port that was not served last wins.
module rr_arbiter2
    import memory_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  grant_t last_grant,
    output logic   valid,
    output grant_t grant
);

    always_comb begin
        valid = req0 | req1;
        grant = grant_t'(0);
        if (req0 && req1) begin
            grant = ~last_grant;
        end else if (req1) begin
            grant = grant_t'(1);
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Two-requester Wishbone arbiter in front of the cache port, one transaction per grant.
// Optional grant watchdog enabled by defining CACHE_ARBITER_TIMEOUT_EN.
module cache_arbiter
    import memory_pkg::*;
#(
    parameter int DATA_SIZE      = 32,
    parameter int BYTE_SIZE      = 8,
    parameter int ADDR_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clock,
    input  logic          reset,
    wishbone_if.secondary wb_if_p0,
    wishbone_if.secondary wb_if_p1,
    wishbone_if.primary   wb_if_s,
    output logic          timeout,
    output arb_state_e    state_dbg
);

    if ((DATA_SIZE % BYTE_SIZE) != 0 || ADDR_SIZE < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("cache_arbiter: inconsistent DATA_SIZE/BYTE_SIZE/ADDR_SIZE/TIMEOUT_CYCLES");
    end

    arb_state_e state, state_next;
    grant_t     last_grant, last_grant_next;
    logic       req0, req1;
    logic       pick_valid;
    grant_t     pick;
    logic       expire;

    assign req0 = wb_if_p0.cyc & wb_if_p0.stb;
    assign req1 = wb_if_p1.cyc & wb_if_p1.stb;

    rr_arbiter2 u_rr (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .grant      (pick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= grant_t'(1);
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    // A grant ends on ack, on the owner dropping cyc, or on watchdog expiry.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        case (state)
            IDLE: begin
                if (pick_valid) state_next = grant_state(pick);
            end
            GRANT0: begin
                if (wb_if_s.ack || !wb_if_p0.cyc || expire) begin
                    state_next      = IDLE;
                    last_grant_next = grant_t'(0);
                end
            end
            GRANT1: begin
                if (wb_if_s.ack || !wb_if_p1.cyc || expire) begin
                    state_next      = IDLE;
                    last_grant_next = grant_t'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wb_if_s.cyc     = 1'b0;
        wb_if_s.stb     = 1'b0;
        wb_if_s.we      = 1'b0;
        wb_if_s.sel     = '0;
        wb_if_s.addr    = '0;
        wb_if_s.dat_o_p = '0;
        wb_if_p0.ack    = 1'b0;
        wb_if_p1.ack    = 1'b0;
        case (state)
            GRANT0: begin
                wb_if_s.cyc     = wb_if_p0.cyc;
                wb_if_s.stb     = wb_if_p0.stb;
                wb_if_s.we      = wb_if_p0.we;
                wb_if_s.sel     = wb_if_p0.sel;
                wb_if_s.addr    = wb_if_p0.addr;
                wb_if_s.dat_o_p = wb_if_p0.dat_o_p;
                wb_if_p0.ack    = wb_if_s.ack;
            end
            GRANT1: begin
                wb_if_s.cyc     = wb_if_p1.cyc;
                wb_if_s.stb     = wb_if_p1.stb;
                wb_if_s.we      = wb_if_p1.we;
                wb_if_s.sel     = wb_if_p1.sel;
                wb_if_s.addr    = wb_if_p1.addr;
                wb_if_s.dat_o_p = wb_if_p1.dat_o_p;
                wb_if_p1.ack    = wb_if_s.ack;
            end
            default: ;
        endcase
    end

    // Read data is shared; only the acked port treats it as valid.
    assign wb_if_p0.dat_i_p = wb_if_s.dat_i_p;
    assign wb_if_p1.dat_i_p = wb_if_s.dat_i_p;
    assign state_dbg        = state;

`ifdef CACHE_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt;

    assign expire = (state != IDLE) && !wb_if_s.ack &&
                    (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (state == IDLE) begin
                wd_cnt <= '0;
            end else if (!wb_if_s.ack) begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end
            if (expire) timeout <= 1'b1;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule
